reaction_ctrl: RTL
==================

Name: reaction_ctrl

Overview:
Sequencer for the millisecond reaction timer in the reaction-time game. Waits for a player start press, inserts a pseudo-random delay, lights the GO LED and starts the timer. It stops the timer on the reaction press and latches the result and the session-best time. Also detects false starts and timeouts. Sits between debounced button and LED pins and the timer's start/stop/clear controls.

Parameters:
CLK_PER_MS, 25000, clock cycles per millisecond for the internal delay prescaler
MIN_DELAY_MS, 1000, minimum random wait before GO
DELAY_MASK, 16'h07FF, mask applied to LFSR for added random delay (ms)
MAX_MS, 9999, reaction timeout threshold on ms_time
SYNC_STAGES, 2, button synchronizer depth

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  1  raw player button, active-high, asynchronous to clk
ms_time  in  14  current count from timer
timer_start  out  1  1-cycle pulse, begins timer counting
timer_stop  out  1  1-cycle pulse, halts timer counting
timer_clear  out  1  1-cycle pulse; integration ORs it into the timer reset
led_go  out  1  GO indicator
result  out  14  last valid reaction time, ms
result_valid  out  1  high while result is displayed
best  out  14  lowest valid result since reset
false_start  out  1  high in FALSE state
timeout  out  1  high in TOUT state

Behaviour:
- Reset (async, rst_n=0) values:
  - All outputs 0, except best = 14'h3FFF.
  - LFSR = 16'hACE1; prescaler = 0; state = IDLE.
- Button handling:
  - btn passes through SYNC_STAGES flops, then a rising-edge detector.
  - press = 1-cycle pulse, SYNC_STAGES+1 cycles after the pin rises.
  - Holding the button produces exactly one press.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state; never all-zero.
- ms tick: prescaler counts 0..CLK_PER_MS-1 and pulses tick on wrap. It is cleared on entry to WAIT.
- States:
  - IDLE:
    - result_valid, false_start and timeout hold their previous values.
    - press -> ARM.
  - ARM (1 cycle):
    - Pulse timer_clear.
    - Load delay_cnt = MIN_DELAY_MS + (lfsr & DELAY_MASK), 16-bit, saturating at 16'hFFFF.
    - Clear result_valid, false_start, timeout.
    - -> WAIT.
  - WAIT:
    - delay_cnt decrements on tick.
    - press -> FALSE.
    - delay_cnt==0 -> GO.
    - If press and zero occur in the same cycle, press wins (FALSE).
  - GO (1 cycle):
    - Pulse timer_start; led_go=1.
    - -> MEAS.
  - MEAS:
    - led_go=1.
    - press -> STOP.
    - ms_time >= MAX_MS -> TOUT.
    - If both occur in the same cycle, press wins.
  - STOP (1 cycle): pulse timer_stop; led_go=0; -> HOLD.
  - HOLD (1 cycle): lets the timer's final increment settle; -> CAP.
  - CAP (1 cycle):
    - result <= ms_time; result_valid <= 1.
    - If ms_time < best, best <= ms_time.
    - -> IDLE.
    - The capture occurs exactly 2 cycles after the timer_stop pulse.
  - FALSE:
    - false_start=1, led_go=0.
    - press -> ARM (retry); result and best are unchanged.
  - TOUT (entry):
    - Pulse timer_stop; timeout=1; led_go=0.
    - Remain in TOUT; press -> ARM; result and best are unchanged.
- Output rules:
  - At most one of timer_start, timer_stop, timer_clear is high in any cycle.
  - Pulses are registered outputs.
- A press in ARM, GO, STOP, HOLD or CAP is ignored (dropped).
- rst_n low mid-operation returns everything to reset values immediately. best is lost.
- Width: ms_time, result and best are 14 bits unsigned. Comparisons are unsigned.

Decomposition:
- Package reaction_pkg holds:
  - State encoding, 4-bit: IDLE, ARM, WAIT, GO, MEAS, STOP, HOLD, CAP, FALSE, TOUT.
  - LFSR seed and tap constant.
  - BEST_INIT = 14'h3FFF.
- One sub-module, btn_sync_edge: synchronizer plus rising-edge pulse, parameterized by SYNC_STAGES.
- LFSR, prescaler and FSM stay in reaction_ctrl.

Test Plan:
Use sim parameters CLK_PER_MS=10, MIN_DELAY_MS=5, DELAY_MASK=16'h0003, MAX_MS=50 throughout. A timer model is attached.
- Reset then idle, no presses -> all outputs 0, best=3FFF; timer_* never pulses over 1000 cycles.
- Normal round:
  - Press, then delay_cnt loaded as 5+(lfsr&3).
  - After delay_cnt*10 (±10) cycles, led_go rises with a single timer_start pulse.
  - Press 120 cycles after GO -> timer_stop pulse.
  - 2 cycles later result=12, result_valid=1, best=12.
- Second round at 80 cycles -> result=8, best=8. Third round at 150 cycles -> result=15, best stays 8.
- False start:
  - Press during WAIT -> false_start=1, led_go never rises, no timer_start.
  - A further press -> ARM with a timer_clear pulse; result and best unchanged.
- Timeout: no press after GO -> when ms_time reaches 50, timer_stop pulses and timeout=1; a later press re-arms.
- Async reset during MEAS:
  - rst_n low with no clk edge -> outputs at reset values immediately, best=3FFF.
  - Held button across rst_n release -> no spurious press.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding and constants for the reaction-timer sequencer.
package reaction_pkg;
   typedef enum logic [3:0] {
      IDLE, ARM, WAIT, GO, MEAS, STOP, HOLD, CAP, FALSE, TOUT
   } state_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [13:0] BEST_INIT = 14'h3FFF;
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/reaction_ctrl_btn_sync_edge.sv
// btn_sync_edge: synchronizes the raw button and emits a one-cycle pulse per rising edge.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_press;
   // Chain and history reset high so a button held through reset never reads as a new press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '1;
         r_prev  <= 1'b1;
         r_press <= 1'b0;
      end else begin
         r_sync[0] <= i_btn;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev  <= r_sync[SYNC_STAGES-1];
         r_press <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end
   assign o_press = r_press;
endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-game sequencer driving timer start/stop/clear, the GO LED and result/best latches.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int          CLK_PER_MS   = 25000,
   parameter int          MIN_DELAY_MS = 1000,
   parameter logic [15:0] DELAY_MASK   = 16'h07FF,
   parameter int          MAX_MS       = 9999,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn,
   input  logic [13:0] ms_time,
   output logic        timer_start,
   output logic        timer_stop,
   output logic        timer_clear,
   output logic        led_go,
   output logic [13:0] result,
   output logic        result_valid,
   output logic [13:0] best,
   output logic        false_start,
   output logic        timeout
);
   localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   state_t        r_state, w_next;
   logic          w_press, w_tick;
   logic          w_start, w_stop, w_clear, w_led;
   logic [15:0]   r_lfsr, r_delay, w_load;
   logic [16:0]   w_sum;
   logic [PW-1:0] r_pre;
   logic          r_start, r_stop, r_clear, r_led, r_rv, r_fs, r_to;
   logic [13:0]   r_result, r_best;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (btn),
      .o_press(w_press)
   );

   assign w_tick = (r_pre == PW'(CLK_PER_MS - 1));
   assign w_sum  = 17'(MIN_DELAY_MS) + {1'b0, r_lfsr & DELAY_MASK};
   assign w_load = w_sum[16] ? 16'hFFFF : w_sum[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr  <= LFSR_SEED;
         r_pre   <= '0;
         r_delay <= '0;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         r_pre  <= (r_state == ARM || w_tick) ? '0 : r_pre + 1'b1;
         if (r_state == ARM) r_delay <= w_load;
         else if (r_state == WAIT && w_tick && r_delay != '0) r_delay <= r_delay - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   end

   // A press always wins over a same-cycle delay expiry or timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = w_press ? ARM : IDLE;
         ARM:         w_next = WAIT;
         WAIT:        w_next = w_press ? FALSE : (r_delay == '0) ? GO : WAIT;
         GO:          w_next = MEAS;
         MEAS:        w_next = w_press ? STOP : (ms_time >= 14'(MAX_MS)) ? TOUT : MEAS;
         STOP:        w_next = HOLD;
         HOLD:        w_next = CAP;
         CAP:         w_next = IDLE;
         FALSE, TOUT: w_next = w_press ? ARM : r_state;
         default:     w_next = IDLE;
      endcase
   end

   always_comb begin
      w_start = (w_next == GO);
      w_stop  = (w_next == STOP) || (w_next == TOUT && r_state != TOUT);
      w_clear = (w_next == ARM);
      w_led   = (w_next == GO) || (w_next == MEAS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start  <= 1'b0;
         r_stop   <= 1'b0;
         r_clear  <= 1'b0;
         r_led    <= 1'b0;
         r_rv     <= 1'b0;
         r_fs     <= 1'b0;
         r_to     <= 1'b0;
         r_result <= '0;
         r_best   <= BEST_INIT;
      end else begin
         r_start <= w_start;
         r_stop  <= w_stop;
         r_clear <= w_clear;
         r_led   <= w_led;
         r_rv    <= (r_state == CAP) ? 1'b1 : (w_next == ARM) ? 1'b0 : r_rv;
         r_fs    <= (w_next == FALSE) ? 1'b1 : (w_next == ARM) ? 1'b0 : r_fs;
         r_to    <= (w_next == TOUT) ? 1'b1 : (w_next == ARM) ? 1'b0 : r_to;
         if (r_state == CAP) r_result <= ms_time;
         if (r_state == CAP && ms_time < r_best) r_best <= ms_time;
      end
   end

   assign timer_start  = r_start;
   assign timer_stop   = r_stop;
   assign timer_clear  = r_clear;
   assign led_go       = r_led;
   assign result       = r_result;
   assign result_valid = r_rv;
   assign best         = r_best;
   assign false_start  = r_fs;
   assign timeout      = r_to;
endmodule
